id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding front end of the execute stage in the 5-stage RV32I core. It captures decoded fields from ID and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. It drives the ALU's `a`, `b` and 4-bit `alu_control` inputs, plus store data and destination info for the EX/MEM register. It supports stall (hold) and flush (bubble insertion) from the hazard/branch logic.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
stall  in  1  hold current ID/EX contents
flush  in  1  load a bubble (valid=0) next cycle
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  register-file read port 1
id_rs2_data  in  XLEN  register-file read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  RA_W  source 1 index
id_rs2  in  RA_W  source 2 index
id_rd  in  RA_W  destination index
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
id_alu_control  in  4  ALU op code (0000 add … 1001 sra, 1111 pass a)
id_a_sel  in  2  00 rs1, 01 pc, 10 zero, 11 reserved (treated as zero)
id_b_sel  in  1  0 rs2, 1 imm
exm_valid  in  1  EX/MEM stage valid
exm_reg_write  in  1  EX/MEM writes rd
exm_mem_read  in  1  EX/MEM holds a load
exm_rd  in  RA_W  EX/MEM destination
exm_result  in  XLEN  EX/MEM ALU result
wb_valid  in  1  MEM/WB valid
wb_reg_write  in  1  MEM/WB writes rd
wb_rd  in  RA_W  MEM/WB destination
wb_data  in  XLEN  final writeback value
alu_a  out  XLEN  ALU operand a
alu_b  out  XLEN  ALU operand b
alu_control  out  4  registered ALU op
store_data  out  XLEN  forwarded rs2 value
ex_rd  out  RA_W  registered rd
ex_reg_write  out  1  registered reg_write gated by ex_valid
ex_mem_read  out  1  registered mem_read gated by ex_valid
ex_valid  out  1  EX stage holds a real instruction
load_use_hazard  out  1  EX operand needs a load result that is not yet available

Behaviour:
- Register update priority per rising edge: `!rst_n` > `flush` > `stall` > load.
  - Reset and flush: `ex_valid`=0. All captured fields are 0: indices, `alu_control`=0000, selects, pc, data, imm.
  - Stall (no flush): all registers hold.
  - Otherwise: capture all `id_*` fields; `ex_valid`=`id_valid`.
- Flush asserted together with stall: bubble wins.
- Forwarding is combinational from registered fields and the current `exm_*`/`wb_*` inputs. It adds zero cycles of latency; an operand is visible in the cycle after capture.
- Forwarded value for source index s (rs1 or rs2):
  - If s==0: use the registered register-file data; x0 is never forwarded.
  - Else if `exm_valid` & `exm_reg_write` & `exm_rd`==s & !`exm_mem_read`: use `exm_result`.
  - Else if `wb_valid` & `wb_reg_write` & `wb_rd`==s: use `wb_data`.
  - Else: use the registered register-file data.
  - EX/MEM has priority over MEM/WB on a double match.
- `load_use_hazard` = `ex_valid` & `exm_valid` & `exm_reg_write` & `exm_mem_read` & `exm_rd`!=0 & (`exm_rd`==rs1 & rs1 is used, or `exm_rd`==rs2 & rs2 is used).
  - rs1 is used when `a_sel`==00.
  - rs2 is used when `b_sel`==0, and always for store data when `mem_read`=0.
  - While the hazard is asserted, the operand falls through to MEM/WB or the register file. The upstream hazard unit must stall/flush; this block does not self-stall.
- `alu_a` mux: 00 forwarded rs1; 01 registered pc; 10/11 zero.
- `alu_b` mux: 0 forwarded rs2; 1 registered imm.
- `store_data` is always forwarded rs2.
- `alu_control`, `ex_rd` and data outputs are driven even when `ex_valid`=0. `ex_reg_write` and `ex_mem_read` are 0 when invalid.
- Reset output values: `alu_a`=0, `alu_b`=0, `alu_control`=0000, `store_data`=0, `ex_rd`=0, `ex_reg_write`=0, `ex_mem_read`=0, `ex_valid`=0, `load_use_hazard`=0.
- Forwarding inputs may change while stalled; outputs track them combinationally.

Test Plan:
- Reset, and reset while stalled with valid contents: after one edge with `rst_n`=0, all outputs are 0 and `alu_control`=0000.
- Plain capture: rs1_data=5, rs2_data=7, a_sel=00, b_sel=0, alu_control=0001, no forwarding matches → next cycle `alu_a`=5, `alu_b`=7, `alu_control`=0001, `ex_valid`=1.
- Double forward: registered rs1=3; exm writes x3=0x11; wb writes x3=0x22 → `alu_a`=0x11. Drop the exm match → `alu_a`=0x22. Set rs1=0 with exm_rd=0 → `alu_a`=registered data.
- Load-use: exm_mem_read=1, exm_rd=rs2=4, b_sel=0 → `load_use_hazard`=1 and `alu_b` not equal to `exm_result`. With b_sel=1 and mem_read=1 → `load_use_hazard`=0.
- Stall then flush: stall 3 cycles while `id_*` changes → outputs hold. Assert stall+flush → next cycle `ex_valid`=0, `ex_reg_write`=0.
- Operand selects: a_sel=01, pc=0x100, b_sel=1, imm=4, op 0000 → `alu_a`=0x100, `alu_b`=4. a_sel=10 with op 1111 → `alu_a`=0.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// ID -> EX decoded-instruction bundle.
// The ID stage drives it; the operand stage samples it.
interface id_ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic [3:0]      id_alu_control;
  logic [1:0]      id_a_sel;
  logic            id_b_sel;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
    output id_alu_control, id_a_sel, id_b_sel
  );

  modport slave (
    input id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
    input id_alu_control, id_a_sel, id_b_sel
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand
// forwarding and load-use hazard detection.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  id_ex_operand_stage_if.slave id,
  input  logic                 exm_valid,
  input  logic                 exm_reg_write,
  input  logic                 exm_mem_read,
  input  logic [RA_W-1:0]      exm_rd,
  input  logic [XLEN-1:0]      exm_result,
  input  logic                 wb_valid,
  input  logic                 wb_reg_write,
  input  logic [RA_W-1:0]      wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [3:0]           alu_control,
  output logic [XLEN-1:0]      store_data,
  output logic [RA_W-1:0]      ex_rd,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_valid,
  output logic                 load_use_hazard
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic [3:0]      alu_control;
    logic [1:0]      a_sel;
    logic            b_sel;
  } id_ex_t;

  id_ex_t d;
  id_ex_t q;

  always_comb begin
    d.valid       = id.id_valid;
    d.pc          = id.id_pc;
    d.rs1_data    = id.id_rs1_data;
    d.rs2_data    = id.id_rs2_data;
    d.imm         = id.id_imm;
    d.rs1         = id.id_rs1;
    d.rs2         = id.id_rs2;
    d.rd          = id.id_rd;
    d.reg_write   = id.id_reg_write;
    d.mem_read    = id.id_mem_read;
    d.alu_control = id.id_alu_control;
    d.a_sel       = id.id_a_sel;
    d.b_sel       = id.id_b_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

  // A load in EX/MEM has no result yet, so it never forwards
  logic exm_fwd;
  logic wb_fwd;
  logic exm_ld;

  assign exm_fwd = exm_valid & exm_reg_write & ~exm_mem_read;
  assign wb_fwd  = wb_valid & wb_reg_write;
  assign exm_ld  = exm_valid & exm_reg_write & exm_mem_read
                 & (exm_rd != '0);

  function automatic logic [XLEN-1:0] fwd(
    input logic [RA_W-1:0] s,
    input logic [XLEN-1:0] rf,
    input logic            e_ok,
    input logic [RA_W-1:0] e_rd,
    input logic [XLEN-1:0] e_val,
    input logic            w_ok,
    input logic [RA_W-1:0] w_rd,
    input logic [XLEN-1:0] w_val
  );
    logic [XLEN-1:0] r;
    r = rf;
    if (s != '0) begin
      if (e_ok && e_rd == s) r = e_val;
      else if (w_ok && w_rd == s) r = w_val;
    end
    return r;
  endfunction

  logic [XLEN-1:0] rs1_f;
  logic [XLEN-1:0] rs2_f;

  assign rs1_f = fwd(q.rs1, q.rs1_data, exm_fwd, exm_rd,
                     exm_result, wb_fwd, wb_rd, wb_data);
  assign rs2_f = fwd(q.rs2, q.rs2_data, exm_fwd, exm_rd,
                     exm_result, wb_fwd, wb_rd, wb_data);

  always_comb begin
    alu_a = '0;
    unique case (q.a_sel)
      2'b00:   alu_a = rs1_f;
      2'b01:   alu_a = q.pc;
      default: alu_a = '0;
    endcase
  end

  assign alu_b       = q.b_sel ? q.imm : rs2_f;
  assign store_data  = rs2_f;
  assign alu_control = q.alu_control;
  assign ex_rd       = q.rd;
  assign ex_valid    = q.valid;
  assign ex_reg_write = q.valid & q.reg_write;
  assign ex_mem_read  = q.valid & q.mem_read;

  // rs2 feeds store data whenever the instruction is not a load
  logic rs1_use;
  logic rs2_use;

  assign rs1_use = (q.a_sel == 2'b00);
  assign rs2_use = ~q.b_sel | ~q.mem_read;

  assign load_use_hazard = q.valid & exm_ld
    & (((exm_rd == q.rs1) & rs1_use)
     | ((exm_rd == q.rs2) & rs2_use));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Vector table plus hand sequences for the ID/EX operand stage,
// checked through an expected-result queue.
module tb_id_ex_operand_stage;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;
  logic exm_valid;
  logic exm_reg_write;
  logic exm_mem_read;
  logic [4:0] exm_rd;
  logic [31:0] exm_result;
  logic wb_valid;
  logic wb_reg_write;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0] alu_control;
  logic [31:0] store_data;
  logic [4:0] ex_rd;
  logic ex_reg_write;
  logic ex_mem_read;
  logic ex_valid;
  logic load_use_hazard;

  id_ex_operand_stage_if #(.XLEN(32), .RA_W(5)) idif ();

  id_ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .flush(flush),
    .id(idif.slave),
    .exm_valid(exm_valid),
    .exm_reg_write(exm_reg_write),
    .exm_mem_read(exm_mem_read),
    .exm_rd(exm_rd),
    .exm_result(exm_result),
    .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_control(alu_control),
    .store_data(store_data),
    .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .ex_valid(ex_valid),
    .load_use_hazard(load_use_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        v;
    logic        haz;
  } out_t;

  typedef struct {
    string       nm;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [3:0]  op;
    logic [1:0]  asel;
    logic        bsel;
    logic        ev;
    logic        ew;
    logic        emr;
    logic [4:0]  erd;
    logic [31:0] eres;
    logic        wv;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    out_t        e;
  } vec_t;

  int tests;
  int fails;
  out_t exp_q[$];
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string nm);
    out_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got empty queue expected entry", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".alu_a"}, alu_a, e.a);
      chk({nm, ".alu_b"}, alu_b, e.b);
      chk({nm, ".store"}, store_data, e.sd);
      chk({nm, ".ctl"}, {28'd0, alu_control}, {28'd0, e.ctl});
      chk({nm, ".rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
      chk({nm, ".rw"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
      chk({nm, ".mr"}, {31'd0, ex_mem_read}, {31'd0, e.mr});
      chk({nm, ".valid"}, {31'd0, ex_valid}, {31'd0, e.v});
      chk({nm, ".haz"}, {31'd0, load_use_hazard}, {31'd0, e.haz});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input vec_t v);
    idif.id_valid       = v.vld;
    idif.id_pc          = v.pc;
    idif.id_rs1_data    = v.r1d;
    idif.id_rs2_data    = v.r2d;
    idif.id_imm         = v.imm;
    idif.id_rs1         = v.rs1;
    idif.id_rs2         = v.rs2;
    idif.id_rd          = v.rd;
    idif.id_reg_write   = v.rw;
    idif.id_mem_read    = v.mr;
    idif.id_alu_control = v.op;
    idif.id_a_sel       = v.asel;
    idif.id_b_sel       = v.bsel;
  endtask

  task automatic set_fwd(input vec_t v);
    exm_valid     = v.ev;
    exm_reg_write = v.ew;
    exm_mem_read  = v.emr;
    exm_rd        = v.erd;
    exm_result    = v.eres;
    wb_valid      = v.wv;
    wb_reg_write  = v.ww;
    wb_rd         = v.wrd;
    wb_data       = v.wdat;
  endtask

  function automatic vec_t blank(input string nm);
    vec_t v;
    v.nm = nm;
    v.vld = 1'b1;
    v.pc = '0; v.r1d = '0; v.r2d = '0; v.imm = '0;
    v.rs1 = '0; v.rs2 = '0; v.rd = '0;
    v.rw = 1'b0; v.mr = 1'b0; v.op = '0;
    v.asel = '0; v.bsel = 1'b0;
    v.ev = 1'b0; v.ew = 1'b0; v.emr = 1'b0;
    v.erd = '0; v.eres = '0;
    v.wv = 1'b0; v.ww = 1'b0; v.wrd = '0; v.wdat = '0;
    v.e = '{a: '0, b: '0, sd: '0, ctl: '0, rd: '0,
            rw: 1'b0, mr: 1'b0, v: 1'b1, haz: 1'b0};
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    set_id(v);
    set_fwd(v);
    exp_q.push_back(v.e);
    tick();
    cmp(v.nm);
  endtask

  out_t zero_o;
  vec_t v;
  vec_t plain;

  initial begin
    tests = 0;
    fails = 0;
    zero_o = '{a: '0, b: '0, sd: '0, ctl: '0, rd: '0,
               rw: 1'b0, mr: 1'b0, v: 1'b0, haz: 1'b0};

    v = blank("plain");
    v.r1d = 32'd5; v.r2d = 32'd7; v.rs1 = 5'd1; v.rs2 = 5'd2;
    v.rd = 5'd3; v.rw = 1'b1; v.op = 4'b0001;
    v.e.a = 32'd5; v.e.b = 32'd7; v.e.sd = 32'd7; v.e.ctl = 4'b0001;
    v.e.rd = 5'd3; v.e.rw = 1'b1;
    plain = v;
    vecs.push_back(v);

    v = blank("dbl_fwd");
    v.rs1 = 5'd3; v.r1d = 32'h9; v.r2d = 32'h33;
    v.ev = 1; v.ew = 1; v.erd = 5'd3; v.eres = 32'h11;
    v.wv = 1; v.ww = 1; v.wrd = 5'd3; v.wdat = 32'h22;
    v.e.a = 32'h11; v.e.b = 32'h33; v.e.sd = 32'h33;
    vecs.push_back(v);

    v.nm = "wb_fwd"; v.ew = 0; v.e.a = 32'h22;
    vecs.push_back(v);

    v = blank("x0_nofwd");
    v.rs1 = 5'd0; v.r1d = 32'h44;
    v.ev = 1; v.ew = 1; v.erd = 5'd0; v.eres = 32'h11;
    v.wv = 1; v.ww = 1; v.wrd = 5'd0; v.wdat = 32'h22;
    v.e.a = 32'h44;
    vecs.push_back(v);

    v = blank("ld_use_rs2");
    v.rs1 = 5'd1; v.r1d = 32'h1; v.rs2 = 5'd4; v.r2d = 32'h55;
    v.ev = 1; v.ew = 1; v.emr = 1; v.erd = 5'd4; v.eres = 32'h66;
    v.e.a = 32'h1; v.e.b = 32'h55; v.e.sd = 32'h55; v.e.haz = 1;
    vecs.push_back(v);

    v = blank("ld_imm_nohaz");
    v.rs1 = 5'd5; v.r1d = 32'h12; v.rs2 = 5'd4; v.r2d = 32'h55;
    v.imm = 32'h8; v.bsel = 1; v.mr = 1; v.rw = 1; v.rd = 5'd7;
    v.ev = 1; v.ew = 1; v.emr = 1; v.erd = 5'd4; v.eres = 32'h66;
    v.e.a = 32'h12; v.e.b = 32'h8; v.e.sd = 32'h55;
    v.e.rd = 5'd7; v.e.rw = 1; v.e.mr = 1;
    vecs.push_back(v);

    v = blank("sel_pc_imm");
    v.asel = 2'b01; v.pc = 32'h100; v.bsel = 1; v.imm = 32'h4;
    v.e.a = 32'h100; v.e.b = 32'h4;
    vecs.push_back(v);

    v = blank("sel_zero");
    v.asel = 2'b10; v.op = 4'b1111; v.rs1 = 5'd1; v.r1d = 32'h5;
    v.rs2 = 5'd2; v.r2d = 32'h9;
    v.e.a = '0; v.e.b = 32'h9; v.e.sd = 32'h9; v.e.ctl = 4'b1111;
    vecs.push_back(v);

    v = blank("sel_rsvd");
    v.asel = 2'b11; v.op = 4'b0010; v.rs1 = 5'd1; v.r1d = 32'h5;
    v.bsel = 1; v.imm = 32'hffff_fffc; v.rs2 = 5'd3; v.r2d = 32'h3;
    v.e.a = '0; v.e.b = 32'hffff_fffc; v.e.sd = 32'h3;
    v.e.ctl = 4'b0010;
    vecs.push_back(v);

    v = blank("exm_invalid");
    v.rs2 = 5'd2; v.r2d = 32'h3;
    v.ev = 0; v.ew = 1; v.erd = 5'd2; v.eres = 32'haa;
    v.wv = 1; v.ww = 1; v.wrd = 5'd2; v.wdat = 32'hbb;
    v.e.b = 32'hbb; v.e.sd = 32'hbb;
    vecs.push_back(v);

    v = blank("ld_use_rs1");
    v.rs1 = 5'd6; v.r1d = 32'h1; v.op = 4'b1001;
    v.ev = 1; v.ew = 1; v.emr = 1; v.erd = 5'd6; v.eres = 32'h99;
    v.wv = 1; v.ww = 1; v.wrd = 5'd6; v.wdat = 32'h77;
    v.e.a = 32'h77; v.e.haz = 1; v.e.ctl = 4'b1001;
    vecs.push_back(v);

    v.nm = "bubble_gate"; v.vld = 0; v.rw = 1; v.mr = 1; v.rd = 5'd9;
    v.e.v = 0; v.e.haz = 0; v.e.rd = 5'd9;
    vecs.push_back(v);

    v = blank("rs1_unused");
    v.asel = 2'b01; v.pc = 32'h200; v.rs1 = 5'd6; v.bsel = 1;
    v.imm = 32'h10; v.r2d = 32'h5;
    v.ev = 1; v.ew = 1; v.emr = 1; v.erd = 5'd6; v.eres = 32'h99;
    v.e.a = 32'h200; v.e.b = 32'h10; v.e.sd = 32'h5;
    vecs.push_back(v);

    stall = 0; flush = 0; rst_n = 0;
    set_id(plain);
    set_fwd(blank("idle"));
    exp_q.push_back(zero_o);
    tick();
    cmp("reset");
    rst_n = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    run_vec(plain);
    stall = 1; rst_n = 0;
    exp_q.push_back(zero_o);
    tick();
    cmp("rst_in_stall");
    stall = 0; rst_n = 1;

    run_vec(plain);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      v = blank("stall_chg");
      v.r1d = 32'hdead_0000 + k; v.r2d = 32'hbeef; v.rs1 = 5'd8;
      v.op = 4'b0110; v.rd = 5'd12; v.asel = 2'b01; v.pc = 32'h40;
      set_id(v);
      exp_q.push_back(plain.e);
      tick();
      cmp("stall_hold");
    end

    exm_valid = 1; exm_reg_write = 1; exm_rd = 5'd1;
    exm_result = 32'habc;
    v.e = plain.e;
    v.e.a = 32'habc;
    exp_q.push_back(v.e);
    #1;
    cmp("stall_fwd");
    set_fwd(blank("idle"));

    flush = 1;
    exp_q.push_back(zero_o);
    tick();
    cmp("stall_flush");
    flush = 0; stall = 0;

    run_vec(plain);
    flush = 1;
    exp_q.push_back(zero_o);
    tick();
    cmp("flush");
    flush = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
